// File: rtl/i2c_master_arbiter.sv
// Round-robin front end that lets NUM_REQUESTERS clients share one i2c_master.
// One request is latched, launched, tracked through master_busy and answered.
module i2c_master_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int REGISTER_WIDTH = 8,
  parameter int ADDRESS_WIDTH  = 7,
  parameter int START_TIMEOUT  = 16
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [NUM_REQUESTERS-1:0]                requester_valid,
  input  logic [NUM_REQUESTERS-1:0]                requester_read_write,
  input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0]  requester_device_address,
  input  logic [NUM_REQUESTERS*REGISTER_WIDTH-1:0] requester_register_address,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]     requester_mosi_data,
  output logic [NUM_REQUESTERS-1:0]                requester_ready,
  output logic [NUM_REQUESTERS-1:0]                response_valid,
  output logic                                     response_error,
  output logic [DATA_WIDTH-1:0]                    response_miso_data,
  input  logic [15:0]                              divider,
  output logic                                     master_enable,
  output logic                                     master_read_write,
  output logic [ADDRESS_WIDTH-1:0]                 master_device_address,
  output logic [REGISTER_WIDTH-1:0]                master_register_address,
  output logic [DATA_WIDTH-1:0]                    master_mosi_data,
  output logic [15:0]                              master_divider,
  input  logic [DATA_WIDTH-1:0]                    master_miso_data,
  input  logic                                     master_busy
);

  localparam int GW   = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int SW   = GW + 1;
  localparam int CW   = $clog2(START_TIMEOUT) + 1;
  localparam int TLIM = START_TIMEOUT - 2;
  localparam int LAST = NUM_REQUESTERS - 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;

  state_t                      state, state_next;
  logic [GW-1:0]               grant, grant_next, last_grant, last_grant_next, winner;
  logic [SW-1:0]               cand_sum;
  logic                        found;
  logic [CW-1:0]               count, count_next;
  logic                        timeout_hit;
  logic [NUM_REQUESTERS-1:0]   winner_onehot, grant_onehot;
  logic                        sel_rw;
  logic [ADDRESS_WIDTH-1:0]    sel_dev;
  logic [REGISTER_WIDTH-1:0]   sel_reg;
  logic [DATA_WIDTH-1:0]       sel_data;

  logic [NUM_REQUESTERS-1:0]   ready_next, resp_valid_next;
  logic                        error_next, enable_next, rw_next;
  logic [DATA_WIDTH-1:0]       miso_next, mosi_next;
  logic [ADDRESS_WIDTH-1:0]    dev_next;
  logic [REGISTER_WIDTH-1:0]   reg_next;
  logic [15:0]                 div_next;

  // Rotating search: first valid requester after the last one granted.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand_sum = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      cand_sum = {1'b0, last_grant} + SW'(k + 1);
      if (cand_sum >= SW'(NUM_REQUESTERS))
        cand_sum = cand_sum - SW'(NUM_REQUESTERS);
      if (!found && requester_valid[cand_sum[GW-1:0]]) begin
        found  = 1'b1;
        winner = cand_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    sel_rw   = 1'b0;
    sel_dev  = '0;
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (winner == GW'(i)) begin
        sel_rw   = requester_read_write[i];
        sel_dev  = requester_device_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_reg  = requester_register_address[i*REGISTER_WIDTH +: REGISTER_WIDTH];
        sel_data = requester_mosi_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign winner_onehot = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << winner;
  assign grant_onehot  = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << grant;
  // Counter value k means the (k+1)-th WAIT_BUSY cycle; leave on the one that makes it START_TIMEOUT-1.
  assign timeout_hit   = (count == CW'(TLIM));

  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= IDLE;
      grant                   <= '0;
      last_grant              <= GW'(LAST);
      count                   <= '0;
      requester_ready         <= '0;
      response_valid          <= '0;
      response_error          <= 1'b0;
      response_miso_data      <= '0;
      master_enable           <= 1'b0;
      master_read_write       <= 1'b0;
      master_device_address   <= '0;
      master_register_address <= '0;
      master_mosi_data        <= '0;
      master_divider          <= '0;
    end else begin
      state                   <= state_next;
      grant                   <= grant_next;
      last_grant              <= last_grant_next;
      count                   <= count_next;
      requester_ready         <= ready_next;
      response_valid          <= resp_valid_next;
      response_error          <= error_next;
      response_miso_data      <= miso_next;
      master_enable           <= enable_next;
      master_read_write       <= rw_next;
      master_device_address   <= dev_next;
      master_register_address <= reg_next;
      master_mosi_data        <= mosi_next;
      master_divider          <= div_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!master_busy && found) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (master_busy) state_next = WAIT_DONE;
                 else if (timeout_hit) state_next = RESPOND;
      WAIT_DONE: if (!master_busy) state_next = RESPOND;
      RESPOND:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Next values for every registered output; fields and response data hold by default.
  always_comb begin
    grant_next      = grant;
    last_grant_next = last_grant;
    count_next      = count;
    ready_next      = '0;
    resp_valid_next = '0;
    enable_next     = 1'b0;
    error_next      = response_error;
    miso_next       = response_miso_data;
    rw_next         = master_read_write;
    dev_next        = master_device_address;
    reg_next        = master_register_address;
    mosi_next       = master_mosi_data;
    div_next        = master_divider;
    case (state)
      IDLE: begin
        if (!master_busy && found) begin
          grant_next      = winner;
          last_grant_next = winner;
          ready_next      = winner_onehot;
          enable_next     = 1'b1;
          rw_next         = sel_rw;
          dev_next        = sel_dev;
          reg_next        = sel_reg;
          mosi_next       = sel_data;
          div_next        = divider;
        end
      end
      ISSUE: count_next = '0;
      WAIT_BUSY: begin
        if (!master_busy) begin
          count_next = count + 1'b1;
          if (timeout_hit) begin
            resp_valid_next = grant_onehot;
            error_next      = 1'b1;
            miso_next       = '0;
          end
        end
      end
      WAIT_DONE: begin
        if (!master_busy) begin
          resp_valid_next = grant_onehot;
          error_next      = 1'b0;
          miso_next       = master_read_write ? master_miso_data : '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter that lets up to NUM_REQUESTERS independent clients share one `i2c_master` instance. It sits between the client logic and the master's command port (`enable`, `read_write`, addresses, `mosi_data`, `divider`). It latches one request at a time, launches it, and tracks the master's `busy` signal to completion. It then returns `miso_data` plus an error flag to the granted requester.

## Interface
Parameters:
- NUM_REQUESTERS, 4, number of clients (2..8)
- DATA_WIDTH, 8, data width; matches i2c_master
- REGISTER_WIDTH, 8, register address width
- ADDRESS_WIDTH, 7, device address width
- START_TIMEOUT, 16, cycles to wait for `busy` to rise after `enable` (>=2)

Ports (requester buses are packed, requester i at slice [i*W +: W]):
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- requester_valid  in  NUM_REQUESTERS  request pending per client
- requester_read_write  in  NUM_REQUESTERS  1 = read, 0 = write
- requester_device_address  in  NUM_REQUESTERS*ADDRESS_WIDTH  target device
- requester_register_address  in  NUM_REQUESTERS*REGISTER_WIDTH  target register
- requester_mosi_data  in  NUM_REQUESTERS*DATA_WIDTH  write data
- requester_ready  out  NUM_REQUESTERS  one-hot, one-cycle pulse: request accepted
- response_valid  out  NUM_REQUESTERS  one-hot, one-cycle pulse: transaction finished
- response_error  out  1  qualified by response_valid: start timeout
- response_miso_data  out  DATA_WIDTH  read data; qualified by response_valid
- divider  in  16  SCL divider, sampled at grant
- master_enable  out  1  to i2c_master enable
- master_read_write  out  1  to i2c_master read_write
- master_device_address  out  ADDRESS_WIDTH  to i2c_master
- master_register_address  out  REGISTER_WIDTH  to i2c_master
- master_mosi_data  out  DATA_WIDTH  to i2c_master
- master_divider  out  16  to i2c_master
- master_miso_data  in  DATA_WIDTH  from i2c_master
- master_busy  in  1  from i2c_master

## Operation
States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND. All outputs are registered.

- **IDLE**
  - Arbitration happens only here, and only if `master_busy`=0.
  - Search starts at (last_grant+1) mod N and takes the first set `requester_valid`.
  - On a winner: latch its fields and `divider` into the master_* registers, record grant index, set last_grant, go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - `master_enable`=1, and `requester_ready[grant]`=1 in the same cycle.
  - Timeout counter cleared. Next state WAIT_BUSY.
- **WAIT_BUSY**
  - `master_busy`=1: go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches START_TIMEOUT-1 with busy still low: set error, response data = 0, go to RESPOND.
- **WAIT_DONE**
  - On `master_busy`=0: capture `master_miso_data` if the request is a read, else 0. Error = 0. Go to RESPOND.
  - No timeout in this state.
- **RESPOND** (1 cycle)
  - `response_valid[grant]`=1, with `response_error` and `response_miso_data` valid.
  - Next state IDLE.
- **Hold rules**
  - master_* field outputs hold their latched values from grant until the next grant.
  - `response_miso_data` and `response_error` hold until the next RESPOND.
- **Requester contract**
  - Hold valid and fields stable until ready.
  - Deasserting valid before grant withdraws the request without side effects.
  - Valid seen again after ready is treated as a new request.
- **Arbitration detail**
  - A requester whose valid stays high after its own response is lowest priority next round.
  - Simultaneous requests are therefore served in rotating order.
- **Reset**
  - State IDLE, last_grant = N-1 (requester 0 first).
  - All outputs 0: enable, ready, response_*, master_* fields, master_divider.
  - Reset mid-transaction aborts with no response to the granted requester.
  - If `master_busy` is still high after reset, IDLE waits for it to drop before granting.

## Timing
- Cycle t, IDLE, valid seen:
  - t+1: ISSUE (`enable` and `ready` high).
  - t+2: first WAIT_BUSY cycle.
- Response 1 cycle after busy is sampled low in WAIT_DONE.
- Timeout path: RESPOND falls at t+2+START_TIMEOUT-1 when busy never rises.
- Back-to-back turnaround: RESPOND → IDLE → ISSUE, so 2 cycles from response_valid to the next master_enable.
- `master_enable` is never high for more than 1 consecutive cycle.
- `master_enable` is never asserted while `master_busy`=1.

## Test plan
- **Single write:** valid[0]=1, dev 0x11, reg 0x05, data 0xA5; model busy high 3 cycles after enable for 20 cycles → ready[0] one pulse, master fields = 0x11/0x05/0xA5, response_valid[0] with error=0, miso=0x00.
- **Single read:** requester 2 read, model returns 0x3C → response_valid[2], response_miso_data=0x3C, error=0; other ready/response bits 0 throughout.
- **Round robin:** valid=4'b1111 held continuously → grant order 0,1,2,3,0,1; with valid=4'b1010 after reset → 1,3,1,3.
- **Start timeout:** busy tied 0 → response_valid after 2+START_TIMEOUT-1 cycles from IDLE with error=1, miso=0; next request served normally.
- **Reset mid-transaction:** assert reset in WAIT_DONE → next cycle all outputs 0, state IDLE, no response_valid for the aborted requester.
- **Busy held high across reset:** with valid[1]=1 → no ready until busy falls, then ready[1] two cycles later.
